writeback_commit: RTL and testbench
===================================

Name: writeback_commit

Overview:
- Consumer end of the execute-stage result interface. Accepts one executed instruction per handshake: result word, updated EFLAGS, destination descriptor.
- Commits the result to the GPR file write port (byte-enabled, 8/16/32-bit) or issues a memory write with req/ack handshake.
- Holds the architectural EFLAGS register and emits a retire pulse per committed instruction.
- Sits between execute and the register file / memory write interface.

Parameters:
- ADDR_W, 32, memory byte-address width.
- MEM_TIMEOUT, 64, cycles allowed in MEM_WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute result valid
- ex_ready  out  1  commit can accept
- ex_result  in  32  result word (execute opnd0_w)
- ex_eflags  in  32  post-execute EFLAGS
- ex_flags_we  in  1  commit ex_eflags at retire
- ex_dst  in  2  destination kind: NONE=0, REG=1, MEM=2; 3 is reserved and treated as NONE
- ex_size  in  2  operand size: SZ8=0, SZ16=1, SZ32=2; 3 is treated as SZ32
- ex_hi8  in  1  8-bit high-byte register (AH..BH); ignored unless SZ8 and REG
- ex_reg  in  3  GPR index
- ex_addr  in  ADDR_W  memory byte address
- gpr_we  out  1  GPR write strobe, one cycle
- gpr_idx  out  3  GPR index
- gpr_wdata  out  32  positioned write data
- gpr_be  out  4  byte enables
- mem_req  out  1  memory write request, level
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  write data, unshifted
- mem_be  out  4  size mask
- mem_ack  in  1  write accepted
- eflags_q  out  32  architectural EFLAGS
- retire  out  1  one-cycle pulse per committed instruction
- wb_err  out  1  sticky memory-timeout error

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0 except eflags_q = 32'h0000_0002 (reserved bit 1 set). Reset forces state IDLE.
- States: IDLE and MEM_WAIT. ex_ready = (state == IDLE).
- Transfer occurs on ex_valid & ex_ready.
- REG transfer:
  - Next cycle: gpr_we=1 and retire=1.
  - SZ32: be=1111, wdata=result.
  - SZ16: be=0011, wdata={16'b0, result[15:0]}.
  - SZ8 lo: be=0001, wdata={24'b0, result[7:0]}.
  - SZ8 hi: be=0010, wdata={16'b0, result[7:0], 8'b0}.
  - Disabled byte lanes drive 0. Stays IDLE, so back-to-back transfers sustain 1/cycle.
- NONE transfer: retire next cycle only; no write.
- MEM transfer:
  - Latch addr, data and size. Enter MEM_WAIT with mem_req=1 next cycle; mem_be = 0001/0011/1111 for SZ8/16/32.
  - Hold mem_req, addr, data and be stable until mem_ack.
  - On the mem_ack cycle: next cycle mem_req=0, retire=1, return to IDLE.
- EFLAGS: eflags_q <= ex_eflags in the same cycle retire is asserted, only if the latched ex_flags_we=1. An instruction that never retires leaves eflags_q unchanged.
- Timeout:
  - A counter clears on MEM_WAIT entry and increments each MEM_WAIT cycle without ack.
  - When it reaches MEM_TIMEOUT: drop mem_req, set wb_err (sticky until reset), no retire, no EFLAGS commit, go to IDLE.
  - If mem_ack coincides with the terminal count, ack wins and the instruction retires normally.
- mem_ack outside MEM_WAIT is ignored.
- Reset during MEM_WAIT deasserts mem_req immediately (asynchronous); no retire.
- ex_valid is not required to be stable while ex_ready=0; inputs are sampled only on transfer.

Optional Feature:
- Macro: WRITEBACK_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt[31:0], reset 0, incremented on each retire pulse; wraps 0xFFFF_FFFF -> 0.
  - Aborted (timed-out) writes do not count.
- Undefined: port and counter absent; other behaviour identical.

Decomposition:
- Shared defines header: DST_NONE/REG/MEM, SZ8/16/32 encodings, EFLAGS reset constant.
- The execute stage must drive the same encodings.
- One combinational sub-module, wb_lane_align: maps size/hi8/result to (wdata, be) for GPR and be for memory.

Test Plan:
- Reset, then REG SZ32 result=0xDEADBEEF, reg=3 -> next cycle gpr_we=1, idx=3, be=1111, wdata=0xDEADBEEF, retire=1.
- REG SZ8 hi8 result=0x000000A5, reg=0 -> be=0010, wdata=0x0000A500. Back-to-back second transfer accepted the following cycle.
- MEM SZ16 addr=0x1000 data=0x1234, flags_we=1, eflags=0x0000_0846 -> mem_req held, be=0011; ex_ready=0. Ack after 5 cycles -> retire and eflags_q=0x846 on the same cycle.
- MEM_TIMEOUT=4, no ack -> mem_req drops after 4 wait cycles, wb_err=1, no retire, eflags_q unchanged, ex_ready returns 1.
- mem_ack coinciding with the terminal count -> retire=1, wb_err=0.
- rst_n low during MEM_WAIT -> mem_req=0 immediately, eflags_q=0x2, no retire after release.

Source files
------------

// File: rtl/writeback_commit_pkg.sv
// Encodings shared between execute and writeback: destination kind, operand size,
// commit FSM states and the architectural EFLAGS reset value.
package writeback_commit_pkg;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_REG  = 2'd1,
    DST_MEM  = 2'd2,
    DST_RSVD = 2'd3
  } dst_e;

  typedef enum logic [1:0] {
    SZ8     = 2'd0,
    SZ16    = 2'd1,
    SZ32    = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] EFLAGS_RST = 32'h0000_0002;

  // EFLAGS carried alongside a pending memory write until it retires
  typedef struct packed {
    logic        flags_we;
    logic [31:0] eflags;
  } flags_pend_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size_e'(size))
      SZ8:     size_mask = 4'b0001;
      SZ16:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational lane steering: positions the result for the GPR byte-enabled write
// port and produces the size mask used for memory writes. Zero latency, no flow control.
module wb_lane_align
  import writeback_commit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        hi8,
  input  logic [31:0] result,
  output logic [31:0] gpr_wdata,
  output logic [3:0]  gpr_be,
  output logic [3:0]  mem_be
);

  always_comb begin
    gpr_wdata = result;
    gpr_be    = 4'b1111;
    mem_be    = size_mask(size);
    case (size_e'(size))
      SZ8: begin
        if (hi8) begin
          gpr_be    = 4'b0010;
          gpr_wdata = {16'b0, result[7:0], 8'b0};
        end else begin
          gpr_be    = 4'b0001;
          gpr_wdata = {24'b0, result[7:0]};
        end
      end
      SZ16: begin
        gpr_be    = 4'b0011;
        gpr_wdata = {16'b0, result[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_commit.sv
// Writeback/commit: 1-cycle registered GPR write or NONE retire; MEM writes hold ex_ready low
// until mem_ack or MEM_TIMEOUT abort. WRITEBACK_RETIRE_CNT_EN adds the retire_cnt counter.
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_eflags,
  input  logic              ex_flags_we,
  input  logic [1:0]        ex_dst,
  input  logic [1:0]        ex_size,
  input  logic              ex_hi8,
  input  logic [2:0]        ex_reg,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic              gpr_we,
  output logic [2:0]        gpr_idx,
  output logic [31:0]       gpr_wdata,
  output logic [3:0]        gpr_be,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic [31:0]       eflags_q,
  output logic              retire,
  output logic              wb_err
`ifdef WRITEBACK_RETIRE_CNT_EN
  ,output logic [31:0]      retire_cnt
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  flags_pend_t       pend_q, pend_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              gpr_we_q, gpr_we_d;
  logic [2:0]        gpr_idx_q, gpr_idx_d;
  logic [31:0]       gpr_wdata_q, gpr_wdata_d;
  logic [3:0]        gpr_be_q, gpr_be_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       eflags_d;
  logic              retire_q, retire_d;
  logic              wb_err_q, wb_err_d;

  logic [31:0]       align_wdata;
  logic [3:0]        align_be;
  logic [3:0]        align_mem_be;

  wb_lane_align u_align (
    .size      (ex_size),
    .hi8       (ex_hi8),
    .result    (ex_result),
    .gpr_wdata (align_wdata),
    .gpr_be    (align_be),
    .mem_be    (align_mem_be)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    tmo_cnt_d   = tmo_cnt_q;
    gpr_we_d    = 1'b0;
    gpr_idx_d   = gpr_idx_q;
    gpr_wdata_d = gpr_wdata_q;
    gpr_be_d    = gpr_be_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    eflags_d    = eflags_q;
    retire_d    = 1'b0;
    wb_err_d    = wb_err_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          case (dst_e'(ex_dst))
            DST_REG: begin
              gpr_we_d    = 1'b1;
              gpr_idx_d   = ex_reg;
              gpr_wdata_d = align_wdata;
              gpr_be_d    = align_be;
              retire_d    = 1'b1;
              if (ex_flags_we) eflags_d = ex_eflags;
            end
            DST_MEM: begin
              state_d     = ST_MEM_WAIT;
              mem_req_d   = 1'b1;
              mem_addr_d  = ex_addr;
              mem_wdata_d = ex_result;
              mem_be_d    = align_mem_be;
              pend_d      = '{flags_we: ex_flags_we, eflags: ex_eflags};
              tmo_cnt_d   = '0;
            end
            default: begin
              retire_d = 1'b1;
              if (ex_flags_we) eflags_d = ex_eflags;
            end
          endcase
        end
      end
      ST_MEM_WAIT: begin
        // ack is tested first so an ack on the terminal count still retires
        if (mem_ack) begin
          mem_req_d = 1'b0;
          retire_d  = 1'b1;
          state_d   = ST_IDLE;
          if (pend_q.flags_we) eflags_d = pend_q.eflags;
        end else if (MEM_TIMEOUT != 0 && tmo_cnt_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          wb_err_d  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      tmo_cnt_q   <= '0;
      gpr_we_q    <= 1'b0;
      gpr_idx_q   <= '0;
      gpr_wdata_q <= '0;
      gpr_be_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      eflags_q    <= EFLAGS_RST;
      retire_q    <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gpr_we_q    <= gpr_we_d;
      gpr_idx_q   <= gpr_idx_d;
      gpr_wdata_q <= gpr_wdata_d;
      gpr_be_q    <= gpr_be_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      eflags_q    <= eflags_d;
      retire_q    <= retire_d;
      wb_err_q    <= wb_err_d;
    end
  end

`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb retire_cnt_d = retire_cnt_q + {31'b0, retire_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign ex_ready  = (state_q == ST_IDLE);
  assign gpr_we    = gpr_we_q;
  assign gpr_idx   = gpr_idx_q;
  assign gpr_wdata = gpr_wdata_q;
  assign gpr_be    = gpr_be_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign retire    = retire_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_writeback_commit.sv
// Bench for writeback_commit: directed vector table, multi-cycle memory/timeout/reset
// sequences, then randomized instructions against a transaction-level model.
module tb_writeback_commit;

  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_eflags = '0;
  logic        ex_flags_we = 1'b0;
  logic [1:0]  ex_dst = '0;
  logic [1:0]  ex_size = '0;
  logic        ex_hi8 = 1'b0;
  logic [2:0]  ex_reg = '0;
  logic [31:0] ex_addr = '0;
  logic        gpr_we;
  logic [2:0]  gpr_idx;
  logic [31:0] gpr_wdata;
  logic [3:0]  gpr_be;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] eflags_q;
  logic        retire;
  logic        wb_err;
`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  writeback_commit #(.ADDR_W(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result), .ex_eflags(ex_eflags),
    .ex_flags_we(ex_flags_we), .ex_dst(ex_dst), .ex_size(ex_size), .ex_hi8(ex_hi8),
    .ex_reg(ex_reg), .ex_addr(ex_addr),
    .gpr_we(gpr_we), .gpr_idx(gpr_idx), .gpr_wdata(gpr_wdata), .gpr_be(gpr_be),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .eflags_q(eflags_q), .retire(retire), .wb_err(wb_err)
`ifdef WRITEBACK_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] m_eflags;
  logic        m_err;
  int          m_retires;

  typedef struct {
    logic [1:0]  dst;
    logic [1:0]  size;
    logic        hi8;
    logic [2:0]  rg;
    logic [31:0] result;
    logic        fwe;
    logic [31:0] efl;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_eflags;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] dst, input logic [1:0] sz, input logic hi,
                       input logic [2:0] rg, input logic [31:0] res, input logic [31:0] addr,
                       input logic fwe, input logic [31:0] efl);
    ex_valid = 1'b1; ex_dst = dst; ex_size = sz; ex_hi8 = hi; ex_reg = rg;
    ex_result = res; ex_addr = addr; ex_flags_we = fwe; ex_eflags = efl;
  endtask

  task automatic scramble_inputs();
    ex_valid = 1'($urandom_range(1, 0));
    ex_dst = 2'($urandom_range(3, 0));
    ex_size = 2'($urandom_range(3, 0));
    ex_hi8 = 1'($urandom_range(1, 0));
    ex_reg = 3'($urandom_range(7, 0));
    ex_result = $urandom; ex_addr = $urandom; ex_eflags = $urandom;
    ex_flags_we = 1'($urandom_range(1, 0));
  endtask

  // Operand size in bytes; a high-byte register moves the single byte up one lane.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] byte_mask32(input int n);
    logic [63:0] m;
    m = (64'd1 << (8 * n)) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [3:0] lane_mask(input int n);
    logic [7:0] m;
    m = (8'd1 << n) - 8'd1;
    return m[3:0];
  endfunction

  task automatic reset_checks();
    chk("rst_gpr_we", 32'(gpr_we), 32'd0);
    chk("rst_gpr_wdata", gpr_wdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_eflags", eflags_q, 32'h0000_0002);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd1, 2'd2, 1'b0, 3'd3, 32'hDEADBEEF, 1'b0, 32'h0,         1'b1, 4'hF, 32'hDEADBEEF, 32'h2};
    tbl[1] = '{2'd1, 2'd0, 1'b1, 3'd0, 32'h000000A5, 1'b1, 32'h00000057,  1'b1, 4'h2, 32'h0000A500, 32'h57};
    tbl[2] = '{2'd1, 2'd1, 1'b0, 3'd5, 32'h12345678, 1'b0, 32'hFFFFFFFF,  1'b1, 4'h3, 32'h00005678, 32'h57};
    tbl[3] = '{2'd1, 2'd0, 1'b0, 3'd7, 32'hFFFFFF7E, 1'b0, 32'h0,         1'b1, 4'h1, 32'h0000007E, 32'h57};
    tbl[4] = '{2'd1, 2'd3, 1'b0, 3'd1, 32'hCAFEF00D, 1'b1, 32'h00000283,  1'b1, 4'hF, 32'hCAFEF00D, 32'h283};
    tbl[5] = '{2'd0, 2'd2, 1'b0, 3'd4, 32'h11111111, 1'b1, 32'h00000893,  1'b0, 4'h0, 32'h0,        32'h893};
    tbl[6] = '{2'd3, 2'd2, 1'b0, 3'd6, 32'h22222222, 1'b0, 32'h00000FFF,  1'b0, 4'h0, 32'h0,        32'h893};
    tbl[7] = '{2'd1, 2'd1, 1'b1, 3'd2, 32'hABCD1234, 1'b0, 32'h0,         1'b1, 4'h3, 32'h00001234, 32'h893};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    #3 rst_n = 1'b1;
    step();

    // table, driven back-to-back with ex_valid held high
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].dst, tbl[i].size, tbl[i].hi8, tbl[i].rg, tbl[i].result, 32'h0,
            tbl[i].fwe, tbl[i].efl);
      step();
      chk($sformatf("tbl%0d_ready", i), 32'(ex_ready), 32'd1);
      chk($sformatf("tbl%0d_retire", i), 32'(retire), 32'd1);
      chk($sformatf("tbl%0d_we", i), 32'(gpr_we), 32'(tbl[i].exp_we));
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_idx", i), 32'(gpr_idx), 32'(tbl[i].rg));
        chk($sformatf("tbl%0d_be", i), 32'(gpr_be), 32'(tbl[i].exp_be));
        chk($sformatf("tbl%0d_wdata", i), gpr_wdata, tbl[i].exp_wdata);
      end
      chk($sformatf("tbl%0d_eflags", i), eflags_q, tbl[i].exp_eflags);
    end
    ex_valid = 1'b0;
    step();
    chk("idle_retire", 32'(retire), 32'd0);
    chk("idle_gpr_we", 32'(gpr_we), 32'd0);

    // MEM SZ16, ack arrives on the terminal timeout count: ack must win
    drive(2'd2, 2'd1, 1'b0, 3'd0, 32'h00001234, 32'h00001000, 1'b1, 32'h00000846);
    step();
    chk("memA_req", 32'(mem_req), 32'd1);
    chk("memA_be", 32'(mem_be), 32'h3);
    chk("memA_addr", mem_addr, 32'h00001000);
    chk("memA_wdata", mem_wdata, 32'h00001234);
    chk("memA_ready", 32'(ex_ready), 32'd0);
    chk("memA_noretire", 32'(retire), 32'd0);
    for (int j = 0; j < TMO - 1; j++) begin
      scramble_inputs();
      step();
      chk("memA_hold_req", 32'(mem_req), 32'd1);
      chk("memA_hold_addr", mem_addr, 32'h00001000);
      chk("memA_hold_be", 32'(mem_be), 32'h3);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    ex_valid = 1'b0;
    chk("memA_retire", 32'(retire), 32'd1);
    chk("memA_req_drop", 32'(mem_req), 32'd0);
    chk("memA_eflags", eflags_q, 32'h00000846);
    chk("memA_no_err", 32'(wb_err), 32'd0);
    chk("memA_ready_back", 32'(ex_ready), 32'd1);
    step();
    chk("memA_single_retire", 32'(retire), 32'd0);

    // MEM SZ32 with no ack: abort after TMO wait cycles
    drive(2'd2, 2'd2, 1'b0, 3'd0, 32'h55AA55AA, 32'h00002004, 1'b1, 32'h00000FD5);
    step();
    ex_valid = 1'b0;
    chk("tmo_req", 32'(mem_req), 32'd1);
    for (int j = 1; j <= TMO; j++) begin
      step();
      if (j < TMO) begin
        chk("tmo_hold_req", 32'(mem_req), 32'd1);
      end else begin
        chk("tmo_req_drop", 32'(mem_req), 32'd0);
        chk("tmo_err", 32'(wb_err), 32'd1);
        chk("tmo_noretire", 32'(retire), 32'd0);
        chk("tmo_eflags", eflags_q, 32'h00000846);
        chk("tmo_ready", 32'(ex_ready), 32'd1);
      end
    end
    drive(2'd1, 2'd2, 1'b0, 3'd6, 32'h0BADF00D, 32'h0, 1'b0, 32'h0);
    step();
    ex_valid = 1'b0;
    chk("post_tmo_retire", 32'(retire), 32'd1);
    chk("err_sticky", 32'(wb_err), 32'd1);

    // asynchronous reset in the middle of MEM_WAIT
    drive(2'd2, 2'd2, 1'b0, 3'd0, 32'h77777777, 32'h00003000, 1'b1, 32'h00000ED7);
    step();
    ex_valid = 1'b0;
    step();
    chk("rstw_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks();
    #2 rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      mem_ack = (j == 0);
      step();
      chk("rstw_noretire", 32'(retire), 32'd0);
      chk("rstw_noreq", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    m_eflags = 32'h2;
    m_err = 1'b0;
    m_retires = 0;

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  dst, sz;
      logic        hi, fwe;
      logic [2:0]  rg;
      logic [31:0] res, addr, efl, exp_wd;
      logic [3:0]  exp_be;
      int          d, k, nb;
      bit          done;
      dst = 2'($urandom_range(3, 0)); sz = 2'($urandom_range(3, 0));
      hi = 1'($urandom_range(1, 0)); fwe = 1'($urandom_range(1, 0));
      rg = 3'($urandom_range(7, 0));
      res = $urandom; addr = $urandom; efl = $urandom;
      nb = nbytes(sz);
      if ($urandom_range(3, 0) == 0) begin
        ex_valid = 1'b0;
        mem_ack = 1'($urandom_range(1, 0));
        step();
        chk("rnd_gap_retire", 32'(retire), 32'd0);
      end
      drive(dst, sz, hi, rg, res, addr, fwe, efl);
      mem_ack = 1'($urandom_range(1, 0));
      step();
      mem_ack = 1'b0;
      if (dst == 2'd1) begin
        exp_wd = (res & byte_mask32(nb)) << ((nb == 1 && hi) ? 8 : 0);
        exp_be = lane_mask(nb) << ((nb == 1 && hi) ? 1 : 0);
        chk("rnd_reg_we", 32'(gpr_we), 32'd1);
        chk("rnd_reg_idx", 32'(gpr_idx), 32'(rg));
        chk("rnd_reg_be", 32'(gpr_be), 32'(exp_be));
        chk("rnd_reg_wdata", gpr_wdata, exp_wd);
        chk("rnd_reg_retire", 32'(retire), 32'd1);
        if (fwe) m_eflags = efl;
        m_retires++;
      end else if (dst == 2'd2) begin
        chk("rnd_mem_req", 32'(mem_req), 32'd1);
        chk("rnd_mem_be", 32'(mem_be), 32'(lane_mask(nb)));
        chk("rnd_mem_addr", mem_addr, addr);
        chk("rnd_mem_wdata", mem_wdata & byte_mask32(nb), res & byte_mask32(nb));
        chk("rnd_mem_ready", 32'(ex_ready), 32'd0);
        chk("rnd_mem_we", 32'(gpr_we), 32'd0);
        d = $urandom_range(TMO + 2, 0);
        k = 0;
        done = 1'b0;
        while (!done) begin
          scramble_inputs();
          if (k == d && d < TMO) begin
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            chk("rnd_ack_retire", 32'(retire), 32'd1);
            chk("rnd_ack_req", 32'(mem_req), 32'd0);
            if (fwe) m_eflags = efl;
            m_retires++;
            done = 1'b1;
          end else begin
            step();
            k++;
            if (k == TMO) begin
              chk("rnd_tmo_req", 32'(mem_req), 32'd0);
              chk("rnd_tmo_retire", 32'(retire), 32'd0);
              m_err = 1'b1;
              done = 1'b1;
            end else begin
              chk("rnd_wait_req", 32'(mem_req), 32'd1);
              chk("rnd_wait_addr", mem_addr, addr);
            end
          end
        end
      end else begin
        chk("rnd_none_we", 32'(gpr_we), 32'd0);
        chk("rnd_none_retire", 32'(retire), 32'd1);
        if (fwe) m_eflags = efl;
        m_retires++;
      end
      chk("rnd_eflags", eflags_q, m_eflags);
      chk("rnd_wb_err", 32'(wb_err), 32'(m_err));
      chk("rnd_ready", 32'(ex_ready), 32'd1);
    end
    ex_valid = 1'b0;
    step();
    chk("final_retire", 32'(retire), 32'd0);
`ifdef WRITEBACK_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 32'(m_retires));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
